// File: rtl/if_fetch_unit.sv
// Instruction fetch front-end: next-PC selection, single-outstanding imem requests,
// and a small PC/instruction queue that drains into decode over valid/ready.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_i,
  output logic [31:0] npc_o,
  output logic        pc_stall_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i
);

  // state  | meaning
  // S_REQ  | no request outstanding
  // S_WAIT | one request outstanding, response will be queued
  // S_DROP | one request outstanding, response will be discarded
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   req_pc;

  logic          redirect;
  logic          granted;
  logic          push;
  logic          pop;
  logic          can_issue;
  logic [CW:0]   credit;
  logic          unused_ok;

  // The PC register owns reset, so RESET_PC is informational only.
  assign unused_ok = ^{RESET_PC, redirect_pc_i[1:0]};

  assign redirect = reset_n && redirect_i;
  assign pop      = id_valid_o && id_ready_i;

  // A response arriving this cycle still needs a slot, so WAIT always counts as in flight.
  assign credit    = {1'b0, count} + (CW+1)'(state == S_WAIT) - (CW+1)'(pop);
  assign can_issue = (state == S_REQ) || (state == S_WAIT && imem_rvalid_i);

  assign imem_req_o  = reset_n && !redirect_i && can_issue && (credit < (CW+1)'(QDEPTH));
  assign imem_addr_o = pc_i;
  assign granted     = imem_req_o && imem_gnt_i;
  assign push        = (state == S_WAIT) && imem_rvalid_i && !redirect;

  always_comb begin
    npc_o      = pc_i;
    pc_stall_o = 1'b1;
    if (redirect) begin
      npc_o      = {redirect_pc_i[31:2], 2'b00};
      pc_stall_o = 1'b0;
    end else if (granted) begin
      npc_o      = pc_i + 32'd4;
      pc_stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_REQ;
      req_pc <= 32'h0;
    end else begin
      if (granted) req_pc <= pc_i;
      case (state)
        S_REQ: begin
          if (granted) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) state <= granted ? S_WAIT : S_REQ;
          else if (redirect) state <= S_DROP;
        end
        S_DROP: begin
          if (imem_rvalid_i) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]    <= 32'h0;
        q_instr[i] <= 32'h0;
      end
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]    <= req_pc;
        q_instr[wr_ptr] <= imem_rdata_i;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign id_valid_o = (count != '0);
  assign id_instr_o = q_instr[rd_ptr];
  assign id_pc_o    = q_pc[rd_ptr];

endmodule
